dma_stride_ci: RTL and testbench
================================

DMA_STRIDE_CI -- requirements
Module: dma_stride_ci

Interface
REQ-001 Parameter customId, 8'd15: custom-instruction number this block answers to.
REQ-002 Parameter MEM_ADDR_W, 9: local buffer address width; depth is 2^MEM_ADDR_W 32-bit words.
REQ-003 Ports: clock in 1 (sole clock); reset in 1 (asynchronous, active-high).
REQ-004 start in 1; ciN in 8; valueA in 32; valueB in 32; done out 1; result out 32: custom-instruction handshake.
REQ-005 requestTransaction out 1; transactionGranted in 1: arbiter handshake.
REQ-006 addressDataIn in 32; endTransactionIn in 1; dataValidIn in 1; busErrorIn in 1; busyIn in 1: bus inputs.
REQ-007 addressDataOut out 32; byteEnablesOut out 4; burstSizeOut out 8; readNotWriteOut out 1; beginTransactionOut out 1; endTransactionOut out 1; dataValidOut out 1: bus outputs.

Function
REQ-008 Instruction accepted only when start=1 and ciN=customId; otherwise done=0 and result=0.
REQ-009 Decode: sel=valueA[MEM_ADDR_W+3:MEM_ADDR_W+1]; we=valueA[MEM_ADDR_W]; addr=valueA[MEM_ADDR_W-1:0].
REQ-010 sel=0: local buffer access; write takes valueB, done in 1 cycle; read done 2 cycles after start, result=word.
REQ-011 sel=1..6: registers busStart(32), memStart(MEM_ADDR_W), blockSize(MEM_ADDR_W+1), burstSize(8), control/status, stride(16); done same cycle as start, result=register value.
REQ-012 Register writes of sel 1,2,3,4,6 ignored while engine busy.
REQ-013 Write sel=5: valueB[1:0]=1 starts bus-to-buffer read, 2 starts buffer-to-bus write; 0 or 3, blockSize=0, or busy: ignored.
REQ-014 Read sel=5: bit0 busy, bit1 bus error latched since last start, other bits 0.
REQ-015 States: IDLE, REQ, BEGIN, RDATA, WDATA, WEND, NEXT.
REQ-016 IDLE->REQ on valid start command; busErr cleared; busy=1.
REQ-017 REQ: requestTransaction=1 until transactionGranted; then BEGIN.
REQ-018 BEGIN (1 cycle): beginTransactionOut=1, addressDataOut=bus address, readNotWriteOut=1 for read, byteEnablesOut=4'hF, burstSizeOut=n-1 with n=min(burstSize+1, remaining); -> RDATA or WDATA.
REQ-019 RDATA: each dataValidIn=1 stores addressDataIn at buffer pointer, pointer+1 modulo 2^MEM_ADDR_W; endTransactionIn -> NEXT.
REQ-020 WDATA: dataValidOut=1 with buffer word; advance only on cycles busyIn=0; after n words -> WEND.
REQ-021 WEND (1 cycle): endTransactionOut=1; -> NEXT.
REQ-022 NEXT: remaining-=n; remaining=0 -> IDLE, busy=0; else bus address+=4*n+4*stride, -> REQ.
REQ-023 busErrorIn=1 in BEGIN/RDATA/WDATA: busErr=1, endTransactionOut=1 one cycle, -> IDLE, busy=0.
REQ-024 Bus outputs are 0 whenever not driven per REQ-017..023.
REQ-025 Local buffer reads by CPU during transfer allowed; same-cycle CPU write and DMA write to one address: DMA wins.

Reset
REQ-026 reset=1 at any time, including mid-burst: state IDLE, all registers and outputs 0, no endTransactionOut issued; buffer contents undefined.

Configuration
REQ-027 Macro DMA_STRIDE_EN defined: stride register and its address increment as REQ-022.
REQ-028 DMA_STRIDE_EN undefined: sel=6 reads 0, writes ignored, bursts contiguous (increment 4*n).

Verification
REQ-029 Write busStart=55, memStart=66, blockSize=7, burstSize=2, control=2 -> three write bursts of 3,3,1 words at 55,67,79, each begin/end exactly once.
REQ-030 Same read (control=1) with stride=4, DMA_STRIDE_EN -> bursts at 55,83,111; buffer 66..72 holds bus words in order.
REQ-031 busyIn=1 for 2 cycles mid-WDATA -> dataValidOut word held, no word skipped or duplicated.
REQ-032 busErrorIn=1 on second data word -> status=2'b10 next read, requestTransaction=0, no further bursts.
REQ-033 reset pulse in RDATA -> all outputs 0 next cycle, status 0, new command accepted.
REQ-034 memStart=510, blockSize=4, MEM_ADDR_W=9 -> buffer addresses 510,511,0,1 written.

Source files
------------

// File: rtl/dma_stride_ci.sv
// Custom-instruction DMA engine: CPU-visible local buffer plus bus burst mover.
// Define DMA_STRIDE_EN to add the stride register and the gap it inserts between bursts.
module dma_stride_ci #(
    parameter logic [7:0]  customId   = 8'd15,
    parameter int unsigned MEM_ADDR_W = 9
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  ciN,
    input  logic [31:0] valueA,
    input  logic [31:0] valueB,
    output logic        done,
    output logic [31:0] result,
    output logic        requestTransaction,
    input  logic        transactionGranted,
    input  logic [31:0] addressDataIn,
    input  logic        endTransactionIn,
    input  logic        dataValidIn,
    input  logic        busErrorIn,
    input  logic        busyIn,
    output logic [31:0] addressDataOut,
    output logic [3:0]  byteEnablesOut,
    output logic [7:0]  burstSizeOut,
    output logic        readNotWriteOut,
    output logic        beginTransactionOut,
    output logic        endTransactionOut,
    output logic        dataValidOut
);
    localparam int unsigned AW    = MEM_ADDR_W;
    localparam int unsigned Depth = 1 << AW;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_REQ   = 3'd1;
    localparam logic [2:0] S_BEGIN = 3'd2;
    localparam logic [2:0] S_RDATA = 3'd3;
    localparam logic [2:0] S_WDATA = 3'd4;
    localparam logic [2:0] S_WEND  = 3'd5;
    localparam logic [2:0] S_NEXT  = 3'd6;

    logic [31:0]   mem [0:Depth-1];

    logic [2:0]    state_q;
    logic [31:0]   bus_start_q, bus_addr_q, rd_data_q;
    logic [AW-1:0] mem_start_q, ptr_q, rd_addr_q;
    logic [AW:0]   block_size_q, remain_q;
    logic [7:0]    burst_size_q;
    logic [8:0]    n_q, cnt_q;
    logic [15:0]   stride_eff;
    logic          bus_err_q, rnw_q, end_err_q, wr_done_q, rd_p1_q, rd_p2_q;

    logic          is_ci, we, busy, reg_wr, dma_go, cpu_mem_we, dma_mem_we, bus_abort;
    logic [2:0]    sel;
    logic [AW-1:0] addr;
    logic [31:0]   burst_p1, rem_ext, n_next, n_m1, rem_after, addr_step, reg_val;
    logic          unused_bits;

    assign is_ci      = start && (ciN == customId);
    assign sel        = valueA[AW+3:AW+1];
    assign we         = valueA[AW];
    assign addr       = valueA[AW-1:0];
    assign busy       = (state_q != S_IDLE);
    assign reg_wr     = is_ci && we && !busy;
    assign dma_go     = reg_wr && (sel == 3'd5) && (block_size_q != '0) &&
                        ((valueB[1:0] == 2'd1) || (valueB[1:0] == 2'd2));
    assign cpu_mem_we = is_ci && we && (sel == 3'd0);
    assign dma_mem_we = (state_q == S_RDATA) && dataValidIn && !busErrorIn;
    assign bus_abort  = busErrorIn &&
                        ((state_q == S_BEGIN) || (state_q == S_RDATA) || (state_q == S_WDATA));

    // Burst length n = min(burstSize + 1, remaining); never exceeds 256.
    assign burst_p1  = 32'(burst_size_q) + 32'd1;
    assign rem_ext   = 32'(remain_q);
    assign n_next    = (rem_ext < burst_p1) ? rem_ext : burst_p1;
    assign n_m1      = n_next - 32'd1;
    assign rem_after = rem_ext - 32'(n_q);
    assign addr_step = (32'(n_q) + 32'(stride_eff)) << 2;

    assign unused_bits = ^{valueA[31:AW+4], n_next[31:9], n_m1[31:8]};

`ifdef DMA_STRIDE_EN
    logic [15:0] stride_q;
    assign stride_eff = stride_q;
`else
    assign stride_eff = 16'd0;
`endif

    // Buffer has no reset; the DMA write is last so it wins an address collision.
    always_ff @(posedge clock) begin
        if (cpu_mem_we) mem[addr] <= valueB;
        if (dma_mem_we) mem[ptr_q] <= addressDataIn;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bus_start_q  <= '0;
            mem_start_q  <= '0;
            block_size_q <= '0;
            burst_size_q <= '0;
`ifdef DMA_STRIDE_EN
            stride_q     <= '0;
`endif
            wr_done_q    <= 1'b0;
            rd_p1_q      <= 1'b0;
            rd_p2_q      <= 1'b0;
            rd_addr_q    <= '0;
            rd_data_q    <= '0;
        end else begin
            if (reg_wr) begin
                case (sel)
                    3'd1: bus_start_q  <= valueB;
                    3'd2: mem_start_q  <= valueB[AW-1:0];
                    3'd3: block_size_q <= valueB[AW:0];
                    3'd4: burst_size_q <= valueB[7:0];
`ifdef DMA_STRIDE_EN
                    3'd6: stride_q     <= valueB[15:0];
`endif
                    default: ;
                endcase
            end
            wr_done_q <= cpu_mem_we;
            rd_p1_q   <= is_ci && !we && (sel == 3'd0);
            rd_addr_q <= addr;
            rd_p2_q   <= rd_p1_q;
            rd_data_q <= mem[rd_addr_q];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            bus_err_q  <= 1'b0;
            end_err_q  <= 1'b0;
            rnw_q      <= 1'b0;
            bus_addr_q <= '0;
            ptr_q      <= '0;
            remain_q   <= '0;
            n_q        <= '0;
            cnt_q      <= '0;
        end else begin
            end_err_q <= 1'b0;
            if (bus_abort) begin
                state_q   <= S_IDLE;
                bus_err_q <= 1'b1;
                end_err_q <= 1'b1;
            end else begin
                case (state_q)
                    S_IDLE: if (dma_go) begin
                        state_q    <= S_REQ;
                        bus_err_q  <= 1'b0;
                        rnw_q      <= (valueB[1:0] == 2'd1);
                        bus_addr_q <= bus_start_q;
                        ptr_q      <= mem_start_q;
                        remain_q   <= block_size_q;
                    end
                    S_REQ: if (transactionGranted) state_q <= S_BEGIN;
                    S_BEGIN: begin
                        n_q     <= n_next[8:0];
                        cnt_q   <= '0;
                        state_q <= rnw_q ? S_RDATA : S_WDATA;
                    end
                    S_RDATA: begin
                        if (dataValidIn) ptr_q <= ptr_q + AW'(1);
                        if (endTransactionIn) state_q <= S_NEXT;
                    end
                    S_WDATA: if (!busyIn) begin
                        ptr_q <= ptr_q + AW'(1);
                        cnt_q <= cnt_q + 9'd1;
                        if (cnt_q == n_q - 9'd1) state_q <= S_WEND;
                    end
                    S_WEND: state_q <= S_NEXT;
                    S_NEXT: begin
                        if (rem_after == 32'd0) begin
                            state_q <= S_IDLE;
                        end else begin
                            remain_q   <= rem_after[AW:0];
                            bus_addr_q <= bus_addr_q + addr_step;
                            state_q    <= S_REQ;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    always_comb begin
        requestTransaction  = 1'b0;
        beginTransactionOut = 1'b0;
        endTransactionOut   = end_err_q;
        dataValidOut        = 1'b0;
        readNotWriteOut     = 1'b0;
        addressDataOut      = '0;
        byteEnablesOut      = '0;
        burstSizeOut        = '0;
        case (state_q)
            S_REQ: requestTransaction = 1'b1;
            S_BEGIN: begin
                beginTransactionOut = 1'b1;
                addressDataOut      = bus_addr_q;
                readNotWriteOut     = rnw_q;
                byteEnablesOut      = 4'hF;
                burstSizeOut        = n_m1[7:0];
            end
            S_WDATA: begin
                dataValidOut   = 1'b1;
                addressDataOut = mem[ptr_q];
            end
            S_WEND: endTransactionOut = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        reg_val = '0;
        case (sel)
            3'd1: reg_val = bus_start_q;
            3'd2: reg_val = 32'(mem_start_q);
            3'd3: reg_val = 32'(block_size_q);
            3'd4: reg_val = 32'(burst_size_q);
            3'd5: reg_val = {30'd0, bus_err_q, busy};
            3'd6: reg_val = 32'(stride_eff);
            default: reg_val = '0;
        endcase
    end

    assign done   = wr_done_q || rd_p2_q || (is_ci && (sel != 3'd0));
    assign result = rd_p2_q ? rd_data_q : ((is_ci && (sel != 3'd0)) ? reg_val : 32'd0);

endmodule

// File: tb/tb_dma_stride_ci.sv
// Scoreboard bench for dma_stride_ci: directed CI and bus stimulus, queued expectations
// checked by an independent negedge monitor. Honors DMA_STRIDE_EN for stride expectations.
module tb_dma_stride_ci;
    localparam int AW = 9;
`ifdef DMA_STRIDE_EN
    localparam logic [31:0] StrideExp = 32'd4;
`else
    localparam logic [31:0] StrideExp = 32'd0;
`endif

    logic        clock = 1'b0, reset = 1'b1;
    logic        start = 1'b0, done;
    logic [7:0]  ciN = 8'd0;
    logic [31:0] valueA = '0, valueB = '0, result;
    logic        requestTransaction, transactionGranted = 1'b0;
    logic [31:0] addressDataIn = '0, addressDataOut;
    logic        endTransactionIn = 1'b0, dataValidIn = 1'b0, busErrorIn = 1'b0, busyIn = 1'b0;
    logic [3:0]  byteEnablesOut;
    logic [7:0]  burstSizeOut;
    logic        readNotWriteOut, beginTransactionOut, endTransactionOut, dataValidOut;

    always #5 clock = ~clock;

    dma_stride_ci dut (
        .clock(clock), .reset(reset), .start(start), .ciN(ciN), .valueA(valueA),
        .valueB(valueB), .done(done), .result(result),
        .requestTransaction(requestTransaction), .transactionGranted(transactionGranted),
        .addressDataIn(addressDataIn), .endTransactionIn(endTransactionIn),
        .dataValidIn(dataValidIn), .busErrorIn(busErrorIn), .busyIn(busyIn),
        .addressDataOut(addressDataOut), .byteEnablesOut(byteEnablesOut),
        .burstSizeOut(burstSizeOut), .readNotWriteOut(readNotWriteOut),
        .beginTransactionOut(beginTransactionOut), .endTransactionOut(endTransactionOut),
        .dataValidOut(dataValidOut)
    );

    typedef struct packed { logic chk; logic [31:0] v; } ci_exp_t;
    typedef struct packed { logic [31:0] a; logic [7:0] bs; logic rnw; } burst_t;

    ci_exp_t     ci_q[$];
    burst_t      bq[$];
    logic [31:0] wd_q[$];
    ci_exp_t     mon_ci;
    burst_t      mon_b;
    logic [31:0] mon_w;
    int          n_pass = 0, n_total = 0, begins_seen = 0, ends_seen = 0;
    int          rd_word = 0;
    logic [31:0] rd_base = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [31:0] outs_or();
        return addressDataOut | result | 32'(byteEnablesOut) | 32'(burstSizeOut) |
               32'({readNotWriteOut, beginTransactionOut, endTransactionOut, dataValidOut,
                    requestTransaction, done});
    endfunction

    function automatic logic [31:0] mk_a(input int sel, input int w, input int addr);
        return 32'((sel << (AW + 1)) | (w << AW) | addr);
    endfunction

    // Monitor: pops and compares whenever the DUT presents a response.
    always @(negedge clock) begin
        if (!reset) begin
            if (done) begin
                if (ci_q.size() == 0) check("ci_unexpected_done", 32'd1, 32'd0);
                else begin
                    mon_ci = ci_q.pop_front();
                    if (mon_ci.chk) check("ci_result", result, mon_ci.v);
                end
            end
            if (beginTransactionOut) begin
                begins_seen++;
                if (bq.size() == 0) check("unexpected_begin", addressDataOut, 32'hFFFF_FFFF);
                else begin
                    mon_b = bq.pop_front();
                    check("burst_addr", addressDataOut, mon_b.a);
                    check("burst_size", 32'(burstSizeOut), 32'(mon_b.bs));
                    check("burst_rnw", 32'(readNotWriteOut), 32'(mon_b.rnw));
                    check("byte_en", 32'(byteEnablesOut), 32'hF);
                end
            end
            if (endTransactionOut) ends_seen++;
            if (dataValidOut && !busyIn) begin
                if (wd_q.size() == 0) check("unexpected_wdata", addressDataOut, 32'hFFFF_FFFF);
                else begin
                    mon_w = wd_q.pop_front();
                    check("wdata", addressDataOut, mon_w);
                end
            end
        end
    end

    task automatic ci(input logic [31:0] a, input logic [31:0] b, input logic chk,
                      input logic [31:0] ev);
        logic got;
        ci_q.push_back({chk, ev});
        @(posedge clock); #1;
        start = 1'b1; ciN = 8'd15; valueA = a; valueB = b;
        got = 1'b0;
        for (int i = 0; i < 6 && !got; i++) begin
            @(negedge clock); got = done;
            @(posedge clock); #1 start = 1'b0;
        end
        if (!got) check("ci_done_timeout", 32'd0, 32'd1);
    endtask

    task automatic reg_wr(input int sel, input logic [31:0] v);
        ci(mk_a(sel, 1, 0), v, 1'b0, 32'd0);
    endtask
    task automatic reg_rd(input int sel, input logic [31:0] ev);
        ci(mk_a(sel, 0, 0), 32'd0, 1'b1, ev);
    endtask
    task automatic mem_wr(input int addr, input logic [31:0] v);
        ci(mk_a(0, 1, addr), v, 1'b0, 32'd0);
    endtask
    task automatic mem_rd(input int addr, input logic [31:0] ev);
        ci(mk_a(0, 0, addr), 32'd0, 1'b1, ev);
    endtask
    task automatic push_begin(input logic [31:0] a, input logic [7:0] bs, input logic rnw);
        bq.push_back({a, bs, rnw});
    endtask
    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Bus slave. act: 0 none, 1 bus error, 2 reset pulse, at word act_word of burst 0.
    task automatic serve(input int nb, input int busy_burst, input int act, input int act_word);
        int n, cnt, cyc;
        logic ok, rnw;
        for (int b = 0; b < nb; b++) begin
            ok = 1'b0;
            for (int i = 0; i < 40 && !ok; i++) begin
                @(negedge clock); ok = requestTransaction;
            end
            if (!ok) begin check("request_seen", 32'd0, 32'd1); return; end
            @(posedge clock); #1 transactionGranted = 1'b1;
            @(posedge clock); #1 transactionGranted = 1'b0;
            @(negedge clock);
            if (!beginTransactionOut) begin check("begin_seen", 32'd0, 32'd1); return; end
            n = int'(burstSizeOut) + 1;
            rnw = readNotWriteOut;
            if (rnw) begin
                for (int k = 0; k < n; k++) begin
                    @(posedge clock); #1;
                    if (act != 0 && b == 0 && k == act_word) begin
                        dataValidIn = 1'b0; endTransactionIn = 1'b0;
                        if (act == 1) busErrorIn = 1'b1;
                        else reset = 1'b1;
                        @(negedge clock);
                        if (act == 2) check("outs_zero_in_reset", outs_or(), 32'd0);
                        @(posedge clock); #1;
                        busErrorIn = 1'b0; reset = 1'b0;
                        @(negedge clock);
                        if (act == 2) check("outs_zero_after_reset", outs_or(), 32'd0);
                        else check("err_end_pulse", 32'(endTransactionOut), 32'd1);
                        return;
                    end
                    dataValidIn = 1'b1;
                    addressDataIn = rd_base + 32'(rd_word);
                    endTransactionIn = (k == n - 1);
                    rd_word++;
                end
                @(posedge clock); #1;
                dataValidIn = 1'b0; endTransactionIn = 1'b0;
            end else begin
                cnt = 0; cyc = 0;
                while (cnt < n && cyc < 50) begin
                    @(posedge clock); #1 busyIn = (b == busy_burst) && (cyc == 1 || cyc == 2);
                    @(negedge clock);
                    if (busyIn) begin
                        check("held_valid", 32'(dataValidOut), 32'd1);
                        check("held_word", addressDataOut,
                              (wd_q.size() > 0) ? wd_q[0] : 32'hDEAD_BEEF);
                    end else if (dataValidOut) cnt++;
                    cyc++;
                end
                if (cnt < n) check("write_words", 32'(cnt), 32'(n));
            end
        end
    endtask

    initial begin
        int b0, e0;
        logic seen;
        idle(3);
        reset = 1'b0;
        idle(1);
        @(negedge clock);
        check("reset_outs_zero", outs_or(), 32'd0);
        for (int s = 1; s <= 6; s++) reg_rd(s, 32'd0);

        // Control write with blockSize=0 must be ignored.
        reg_wr(5, 32'd1);
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin @(negedge clock); seen |= requestTransaction; end
        check("zero_block_no_req", 32'(seen), 32'd0);
        reg_rd(5, 32'd0);

        for (int i = 0; i < 7; i++) mem_wr(66 + i, 32'hB000_0000 + 32'(i));
        reg_wr(1, 32'd55); reg_wr(2, 32'd66); reg_wr(3, 32'd7); reg_wr(4, 32'd2);
        reg_rd(1, 32'd55); reg_rd(2, 32'd66); reg_rd(3, 32'd7); reg_rd(4, 32'd2);
        mem_rd(68, 32'hB000_0002);

        // Wrong custom-instruction number: no response.
        @(posedge clock); #1;
        start = 1'b1; ciN = 8'd14; valueA = mk_a(1, 0, 0);
        @(negedge clock);
        check("wrong_cin_quiet", 32'(done) | result, 32'd0);
        @(posedge clock); #1 start = 1'b0;

        // Buffer-to-bus write: 3,3,1 words with a busy stall in burst 1.
        b0 = begins_seen; e0 = ends_seen;
        push_begin(32'd55, 8'd2, 1'b0); push_begin(32'd67, 8'd2, 1'b0);
        push_begin(32'd79, 8'd0, 1'b0);
        for (int i = 0; i < 7; i++) wd_q.push_back(32'hB000_0000 + 32'(i));
        reg_wr(5, 32'd2);
        serve(3, 1, 0, 0);
        idle(4);
        check("wr_begins", 32'(begins_seen - b0), 32'd3);
        check("wr_ends", 32'(ends_seen - e0), 32'd3);
        reg_rd(5, 32'd0);

        // Bus-to-buffer read with stride.
        reg_wr(6, 32'd4);
        reg_rd(6, StrideExp);
        b0 = begins_seen; e0 = ends_seen;
        push_begin(32'd55, 8'd2, 1'b1);
        push_begin(32'd67 + 4 * StrideExp, 8'd2, 1'b1);
        push_begin(32'd79 + 8 * StrideExp, 8'd0, 1'b1);
        rd_base = 32'hA000_0000; rd_word = 0;
        reg_wr(5, 32'd1);
        serve(3, -1, 0, 0);
        idle(4);
        check("rd_begins", 32'(begins_seen - b0), 32'd3);
        check("rd_ends", 32'(ends_seen - e0), 32'd0);
        for (int i = 0; i < 7; i++) mem_rd(66 + i, 32'hA000_0000 + 32'(i));

        // Bus error on the second data word.
        b0 = begins_seen; e0 = ends_seen;
        push_begin(32'd55, 8'd2, 1'b1);
        rd_base = 32'hE000_0000; rd_word = 0;
        reg_wr(5, 32'd1);
        serve(1, -1, 1, 1);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin @(negedge clock); seen |= requestTransaction; end
        check("err_no_req", 32'(seen), 32'd0);
        check("err_begins", 32'(begins_seen - b0), 32'd1);
        check("err_ends", 32'(ends_seen - e0), 32'd1);
        reg_rd(5, 32'd2);

        // Reset pulse in the middle of a read burst.
        e0 = ends_seen;
        push_begin(32'd55, 8'd2, 1'b1);
        reg_wr(5, 32'd1);
        serve(1, -1, 2, 1);
        idle(3);
        check("rst_no_end", 32'(ends_seen - e0), 32'd0);
        reg_rd(5, 32'd0);
        reg_rd(1, 32'd0);

        // Buffer pointer wraps from 511 to 0.
        reg_wr(1, 32'd100); reg_wr(2, 32'd510); reg_wr(3, 32'd4); reg_wr(4, 32'd3);
        push_begin(32'd100, 8'd3, 1'b1);
        rd_base = 32'hC000_0000; rd_word = 0;
        reg_wr(5, 32'd1);
        serve(1, -1, 0, 0);
        idle(4);
        mem_rd(510, 32'hC000_0000); mem_rd(511, 32'hC000_0001);
        mem_rd(0, 32'hC000_0002);   mem_rd(1, 32'hC000_0003);
        reg_rd(5, 32'd0);

        idle(2);
        check("ci_queue_drained", 32'(ci_q.size()), 32'd0);
        check("burst_queue_drained", 32'(bq.size()), 32'd0);
        check("wdata_queue_drained", 32'(wd_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d", n_pass, n_total);
        $fatal(1);
    end
endmodule
